// File: rtl/md_issue_ctrl.sv
// Issue control for the multiply/divide unit: start/select decode, HI/LO write
// strobes, D-stage stall, busy-cycle latency capture and sticky protocol/timeout flags.
module md_issue_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] op_d,
   input  logic [3:0] op_e,
   input  logic       busy,
   output logic       start,
   output logic [2:0] mdctr,
   output logic       hiwrite,
   output logic       lowrite,
   output logic       stall_d,
   output logic [7:0] last_lat,
   output logic       err_proto,
   output logic       err_tmo
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      BUSY  = 2'd2
   } state_t;

   localparam logic [7:0] TMO_LIMIT = 8'd64;

   state_t     state;
   logic [7:0] cnt;

   logic       arith_e;
   logic       hilo_e;
   logic       md_d;
   logic       engaged;
   logic       occupied;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      arith_e  = (op_e >= 4'd1) && (op_e <= 4'd4);
      hilo_e   = (op_e == 4'd7) || (op_e == 4'd8);
      md_d     = (op_d >= 4'd1) && (op_d <= 4'd8);
      // Occupancy without the start term, so start does not depend on itself.
      engaged  = busy || (state != IDLE);
      start    = rst && arith_e && !engaged;
      occupied = start || engaged;
      stall_d  = md_d && occupied;
      hiwrite  = rst && (op_e == 4'd7);
      lowrite  = rst && (op_e == 4'd8);

      mdctr = 3'd0;
      case (op_e)
         4'd1:    mdctr = 3'd0;
         4'd2:    mdctr = 3'd2;
         4'd3:    mdctr = 3'd1;
         4'd4:    mdctr = 3'd3;
         default: mdctr = 3'd0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         last_lat  <= 8'd0;
         err_proto <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         if ((arith_e && engaged) || (hilo_e && engaged))
            err_proto <= 1'b1;

         case (state)
            IDLE: begin
               if (start)
                  state <= ARMED;
            end
            ARMED: begin
               if (busy) begin
                  state <= BUSY;
                  cnt   <= 8'd1;
               end else begin
                  state    <= IDLE;
                  last_lat <= 8'd0;
               end
            end
            BUSY: begin
               if (!busy) begin
                  state    <= IDLE;
                  last_lat <= cnt;
                  cnt      <= 8'd0;
               end else if (cnt >= TMO_LIMIT) begin
                  // Busy outlived the limit: give up so the D stage is released.
                  state    <= IDLE;
                  last_lat <= TMO_LIMIT;
                  cnt      <= 8'd0;
                  err_tmo  <= 1'b1;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl; inputs change 1 ns after the
// rising edge and outputs are compared mid-cycle.
module tb_md_issue_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] op_d;
   logic [3:0] op_e;
   logic       busy;
   logic       start;
   logic [2:0] mdctr;
   logic       hiwrite;
   logic       lowrite;
   logic       stall_d;
   logic [7:0] last_lat;
   logic       err_proto;
   logic       err_tmo;

   int n_cmp = 0;
   int n_bad = 0;

   md_issue_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .op_d      (op_d),
      .op_e      (op_e),
      .busy      (busy),
      .start     (start),
      .mdctr     (mdctr),
      .hiwrite   (hiwrite),
      .lowrite   (lowrite),
      .stall_d   (stall_d),
      .last_lat  (last_lat),
      .err_proto (err_proto),
      .err_tmo   (err_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b0;
      op_d = 4'd0;
      op_e = 4'd0;
      busy = 1'b0;
      #2;
      check("rst_last_lat", last_lat, 8'd0);
      check("rst_err_proto", {7'd0, err_proto}, 8'd0);
      check("rst_err_tmo", {7'd0, err_tmo}, 8'd0);
      op_e = 4'd7;
      #1;
      check("rst_hiwrite_blocked", {7'd0, hiwrite}, 8'd0);
      op_e = 4'd1;
      op_d = 4'd3;
      #1;
      check("rst_start_blocked", {7'd0, start}, 8'd0);
      check("rst_stall_idle", {7'd0, stall_d}, 8'd0);
      op_e = 4'd0;
      op_d = 4'd0;
      cyc();
      rst = 1'b1;
      cyc();

      // mult, 5 busy cycles, mfhi waiting in D
      op_e = 4'd1;
      op_d = 4'd5;
      #1;
      check("mult_start", {7'd0, start}, 8'd1);
      check("mult_mdctr", {5'd0, mdctr}, 8'd0);
      check("mult_stall_issue", {7'd0, stall_d}, 8'd1);
      cyc();
      op_e = 4'd0;
      for (int i = 0; i < 5; i++) begin
         busy = 1'b1;
         #1;
         check("mult_stall_busy", {7'd0, stall_d}, 8'd1);
         check("mult_no_restart", {7'd0, start}, 8'd0);
         cyc();
      end
      busy = 1'b0;
      #1;
      check("mult_stall_drain", {7'd0, stall_d}, 8'd1);
      cyc();
      check("mult_last_lat", last_lat, 8'd5);
      check("mult_idle_stall", {7'd0, stall_d}, 8'd0);

      // div, 10 busy cycles, mflo waiting in D, then back-to-back multu
      op_e = 4'd3;
      op_d = 4'd6;
      #1;
      check("div_start", {7'd0, start}, 8'd1);
      check("div_mdctr", {5'd0, mdctr}, 8'd1);
      cyc();
      op_e = 4'd0;
      for (int i = 0; i < 10; i++) begin
         busy = 1'b1;
         #1;
         check("div_stall_busy", {7'd0, stall_d}, 8'd1);
         cyc();
      end
      busy = 1'b0;
      cyc();
      check("div_last_lat", last_lat, 8'd10);
      check("div_stall_released", {7'd0, stall_d}, 8'd0);
      op_d = 4'd0;
      op_e = 4'd2;
      #1;
      check("b2b_start", {7'd0, start}, 8'd1);
      check("b2b_mdctr", {5'd0, mdctr}, 8'd2);
      cyc();
      op_e = 4'd0;
      cyc();
      check("armed_nobusy_last_lat", last_lat, 8'd0);

      // mthi then mtlo with the unit idle
      op_d = 4'd6;
      op_e = 4'd7;
      #1;
      check("mthi_hiwrite", {7'd0, hiwrite}, 8'd1);
      check("mthi_lowrite", {7'd0, lowrite}, 8'd0);
      check("mthi_stall", {7'd0, stall_d}, 8'd0);
      cyc();
      op_e = 4'd8;
      #1;
      check("mtlo_hiwrite", {7'd0, hiwrite}, 8'd0);
      check("mtlo_lowrite", {7'd0, lowrite}, 8'd1);
      cyc();
      op_e = 4'd0;
      op_d = 4'd0;
      #1;
      check("hilo_lowrite_off", {7'd0, lowrite}, 8'd0);
      check("hilo_err_proto", {7'd0, err_proto}, 8'd0);

      // divu issued while the unit is busy with a mult
      op_e = 4'd1;
      #1;
      check("proto_first_start", {7'd0, start}, 8'd1);
      cyc();
      op_e = 4'd0;
      busy = 1'b1;
      cyc();
      op_e = 4'd4;
      #1;
      check("proto_no_second_start", {7'd0, start}, 8'd0);
      cyc();
      check("proto_err_set", {7'd0, err_proto}, 8'd1);
      op_e = 4'd0;
      busy = 1'b0;
      cyc();
      check("proto_last_lat", last_lat, 8'd2);
      check("proto_err_sticky", {7'd0, err_proto}, 8'd1);

      // busy stuck high for 100 cycles
      op_e = 4'd1;
      cyc();
      op_e = 4'd0;
      op_d = 4'd2;
      for (int i = 1; i <= 100; i++) begin
         busy = 1'b1;
         cyc();
         if (i == 64) check("tmo_not_yet", {7'd0, err_tmo}, 8'd0);
         if (i == 65) begin
            check("tmo_set", {7'd0, err_tmo}, 8'd1);
            check("tmo_last_lat", last_lat, 8'd64);
         end
      end
      busy = 1'b0;
      #1;
      check("tmo_stall_after", {7'd0, stall_d}, 8'd0);
      check("tmo_err_sticky", {7'd0, err_tmo}, 8'd1);
      check("tmo_proto_sticky", {7'd0, err_proto}, 8'd1);

      // reset asserted in BUSY with multu presented
      op_e = 4'd1;
      cyc();
      op_e = 4'd0;
      busy = 1'b1;
      cyc();
      cyc();
      op_e = 4'd2;
      #1;
      check("pre_rst_no_start", {7'd0, start}, 8'd0);
      rst = 1'b0;
      #1;
      check("midrst_start", {7'd0, start}, 8'd0);
      check("midrst_err_proto", {7'd0, err_proto}, 8'd0);
      check("midrst_err_tmo", {7'd0, err_tmo}, 8'd0);
      check("midrst_last_lat", last_lat, 8'd0);
      check("midrst_stall_busy", {7'd0, stall_d}, 8'd1);
      busy = 1'b0;
      #1;
      check("midrst_stall_nobusy", {7'd0, stall_d}, 8'd0);
      cyc();
      rst = 1'b1;
      #1;
      check("post_rst_start", {7'd0, start}, 8'd1);
      check("post_rst_mdctr", {5'd0, mdctr}, 8'd2);
      cyc();
      op_e = 4'd0;
      cyc();
      check("post_rst_last_lat", last_lat, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
